// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared state type and constants for the sound-effect arbiter
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } sfx_state_t;

    localparam logic [7:0] SOUND_SILENT = 8'h00;
    localparam int         SFX_LEN_W    = 16;

endpackage

// File: rtl/sfx_prio_enc.sv
// rtl/sfx_prio_enc.sv - lowest-index-first priority encoder with valid flag
module sfx_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  bits,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // scan downward so the lowest set index is the last assignment and wins
    always_comb begin
        valid = |bits;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/sfx_arbiter.sv
// rtl/sfx_arbiter.sv - fixed-priority sound-effect arbiter/sequencer; optional SFX_PREEMPT_EN enables preemption
module sfx_arbiter
    import sfx_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LEN_W     = SFX_LEN_W,
    parameter int GAP_TICKS = 64
) (
    input  logic                       Clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_sound,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [7:0]                 Sound,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic [NUM_REQ-1:0]         pending
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int RW    = (LEN_W > GAP_W) ? LEN_W : GAP_W;

    sfx_state_t       state, state_nxt;
    logic [RW-1:0]    remain, remain_nxt;
    logic [7:0]       slot_sound [NUM_REQ];
    logic [LEN_W-1:0] slot_len   [NUM_REQ];

    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx;
    logic               preempt;
    logic               load_en;
    logic [RW-1:0]      load_len;
    logic [7:0]         sound_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] clr_mask;
    logic [ID_W-1:0]    id_nxt;

    sfx_prio_enc #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_prio_enc (
        .bits  (pending),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // a zero-length request still plays for one tick
    assign load_len = (slot_len[sel_idx] == '0) ? RW'(1) : RW'(slot_len[sel_idx]);

`ifdef SFX_PREEMPT_EN
    assign preempt = sel_valid && (sel_idx < active_id);
`else
    assign preempt = 1'b0;
`endif

    // state register and duration/gap countdown
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    // next state: grant from IDLE, count ticks in PLAY and GAP, optional preempt in PLAY
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    load_en    = 1'b1;
                    state_nxt  = PLAY;
                    remain_nxt = load_len;
                end
            end
            PLAY: begin
                if (preempt) begin
                    load_en    = 1'b1;
                    remain_nxt = load_len;
                end else if (sample_tick) begin
                    if (remain == RW'(1)) begin
                        if (GAP_TICKS == 0) begin
                            state_nxt  = IDLE;
                            remain_nxt = '0;
                        end else begin
                            state_nxt  = GAP;
                            remain_nxt = RW'(GAP_TICKS);
                        end
                    end else begin
                        remain_nxt = remain - RW'(1);
                    end
                end
            end
            GAP: begin
                if (sample_tick) begin
                    if (remain == RW'(1)) begin
                        state_nxt  = IDLE;
                        remain_nxt = '0;
                    end else begin
                        remain_nxt = remain - RW'(1);
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                remain_nxt = '0;
            end
        endcase
    end

    // next output values: load the selected slot on a start, silence outside PLAY
    always_comb begin
        sound_nxt = Sound;
        grant_nxt = '0;
        clr_mask  = '0;
        id_nxt    = active_id;
        if (load_en) begin
            sound_nxt          = slot_sound[sel_idx];
            grant_nxt[sel_idx] = 1'b1;
            clr_mask[sel_idx]  = 1'b1;
            id_nxt             = sel_idx;
        end else if (state_nxt != PLAY) begin
            sound_nxt = SOUND_SILENT;
        end
    end

    // registered outputs and request slots; a same-cycle req re-arms a slot being granted
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            Sound     <= SOUND_SILENT;
            busy      <= 1'b0;
            grant     <= '0;
            active_id <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_sound[i] <= SOUND_SILENT;
                slot_len[i]   <= '0;
            end
        end else begin
            pending   <= (pending & ~clr_mask) | req;
            Sound     <= sound_nxt;
            busy      <= (state_nxt != IDLE);
            grant     <= grant_nxt;
            active_id <= id_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    slot_sound[i] <= req_sound[i*8 +: 8];
                    slot_len[i]   <= req_len[i*LEN_W +: LEN_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_arbiter.sv
// tb/tb_sfx_arbiter.sv - self-checking bench for sfx_arbiter (vectors, corner sequences, random vs model)
module tb_sfx_arbiter;

    localparam int NREQ = 4;
    localparam int LW   = 16;
    localparam int GAP  = 8;
`ifdef SFX_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic                 Clk         = 1'b0;
    logic                 reset_n     = 1'b1;
    logic                 sample_tick = 1'b0;
    logic [NREQ-1:0]      req         = '0;
    logic [NREQ*8-1:0]    req_sound   = '0;
    logic [NREQ*LW-1:0]   req_len     = '0;
    logic [7:0]           Sound;
    logic                 busy;
    logic [NREQ-1:0]      grant;
    logic [1:0]           active_id;
    logic [NREQ-1:0]      pending;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model: effect progress as plain tick counts
    bit [NREQ-1:0] m_pend;
    logic [7:0]    m_snd [NREQ];
    int            m_len [NREQ];
    logic [7:0]    m_sound;
    bit            m_busy;
    bit [NREQ-1:0] m_grant;
    int            m_id;
    int            m_play;
    int            m_gap;

    typedef struct {
        int         id;
        logic [7:0] code;
        int         len;
        logic [3:0] exp_grant;
        int         exp_ticks;
    } vec_t;
    vec_t vecs [4];

    sfx_arbiter #(
        .NUM_REQ   (NREQ),
        .LEN_W     (LW),
        .GAP_TICKS (GAP)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .req         (req),
        .req_sound   (req_sound),
        .req_len     (req_len),
        .Sound       (Sound),
        .busy        (busy),
        .grant       (grant),
        .active_id   (active_id),
        .pending     (pending)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_sound = 8'h00;
        m_busy  = 1'b0;
        m_grant = '0;
        m_id    = 0;
        m_play  = 0;
        m_gap   = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_snd[i] = 8'h00;
            m_len[i] = 0;
        end
    endtask

    task automatic model_edge();
        int sel;
        bit start;
        sel   = -1;
        start = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (m_pend[i] && sel < 0) sel = i;
        end
        if (m_play == 0 && m_gap == 0) begin
            start = (sel >= 0);
        end else if (m_play > 0) begin
            if (PRE && sel >= 0 && sel < m_id) begin
                start = 1'b1;
            end else if (sample_tick) begin
                m_play--;
                if (m_play == 0) m_gap = GAP;
            end
        end else if (sample_tick) begin
            m_gap--;
        end
        m_grant = '0;
        if (start) begin
            m_play       = (m_len[sel] == 0) ? 1 : m_len[sel];
            m_gap        = 0;
            m_sound      = m_snd[sel];
            m_grant[sel] = 1'b1;
            m_id         = sel;
            m_pend[sel]  = 1'b0;
        end
        if (m_play == 0) m_sound = 8'h00;
        m_busy = (m_play > 0) || (m_gap > 0);
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                m_pend[i] = 1'b1;
                m_snd[i]  = req_sound[i*8 +: 8];
                m_len[i]  = int'(req_len[i*LW +: LW]);
            end
        end
    endtask

    task automatic step();
        logic [18:0] mv;
        @(posedge Clk);
        model_edge();
        #1;
        mv = {m_sound, m_busy, m_grant, m_id[1:0], m_pend};
        chk("cycle", {Sound, busy, grant, active_id, pending}, mv);
        req = '0;
        cyc++;
        sample_tick = (cyc % 4 == 0);
    endtask

    task automatic set_req(input int i, input logic [7:0] code, input int len);
        req[i]                 = 1'b1;
        req_sound[i*8 +: 8]    = code;
        req_len[i*LW +: LW]    = LW'(len);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_sound", Sound, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_active_id", active_id, 0);
        chk("rst_pending", pending, 0);
        @(posedge Clk);
        #1;
        reset_n = 1'b1;
        req     = '0;
        model_reset();
    endtask

    initial begin
        int cnt;
        int b;
        int k;
        int silent;
        bit got;
        logic [3:0] g_seen [2];
        int         id_seen [2];
        int         g0_count;
        int         seen10;
        logic [7:0] snd_at_grant;

        vecs[0] = '{2, 8'h31, 5, 4'b0100, 5};
        vecs[1] = '{0, 8'hA5, 0, 4'b0001, 1};
        vecs[2] = '{3, 8'h7E, 1, 4'b1000, 1};
        vecs[3] = '{1, 8'hFF, 3, 4'b0010, 3};

        model_reset();
        #2;

        // single effects: latency, duration in ticks, gap length
        for (int r = 0; r < 4; r++) begin
            do_reset();
            set_req(vecs[r].id, vecs[r].code, vecs[r].len);
            step();
            chk("vec_pending", pending, vecs[r].exp_grant);
            chk("vec_sound_early", Sound, 0);
            step();
            chk("vec_grant", grant, vecs[r].exp_grant);
            chk("vec_sound", Sound, vecs[r].code);
            chk("vec_busy", busy, 1);
            chk("vec_active_id", active_id, vecs[r].id);
            cnt = 0;
            b = 0;
            while (Sound == vecs[r].code && b < 500) begin
                if (sample_tick) cnt++;
                step();
                b++;
            end
            chk("vec_play_ticks", cnt, vecs[r].exp_ticks);
            chk("vec_gap_busy", busy, 1);
            cnt = 0;
            b = 0;
            while (busy && b < 1000) begin
                if (sample_tick) cnt++;
                step();
                b++;
            end
            chk("vec_gap_ticks", cnt, GAP);
        end

        // simultaneous requests on 3 and 1
        do_reset();
        set_req(3, 8'h33, 3);
        set_req(1, 8'h11, 3);
        k = 0;
        b = 0;
        while (k < 2 && b < 2000) begin
            step();
            b++;
            if (grant != '0) begin
                g_seen[k]  = grant;
                id_seen[k] = int'(active_id);
                k++;
            end
        end
        chk("two_req_count", k, 2);
        chk("two_req_grant0", g_seen[0], 4'b0010);
        chk("two_req_id0", id_seen[0], 1);
        chk("two_req_grant1", g_seen[1], 4'b1000);
        chk("two_req_id1", id_seen[1], 3);

        // repeated req on slot 0 while another effect is in its gap: latest wins, plays once
        do_reset();
        set_req(3, 8'h44, 2);
        b = 0;
        step();
        while (!(busy && Sound == 8'h00) && b < 500) begin
            step();
            b++;
        end
        chk("dbl_reach_gap", (b < 500), 1);
        set_req(0, 8'h10, 4);
        step();
        step();
        step();
        set_req(0, 8'h22, 4);
        g0_count = 0;
        seen10 = 0;
        snd_at_grant = 8'h00;
        for (int i = 0; i < 400; i++) begin
            step();
            if (grant[0]) begin
                g0_count++;
                snd_at_grant = Sound;
            end
            if (Sound == 8'h10) seen10++;
        end
        chk("dbl_grants", g0_count, 1);
        chk("dbl_old_code_seen", seen10, 0);
        chk("dbl_code", snd_at_grant, 8'h22);

        // reset asserted mid-PLAY with three ticks left
        do_reset();
        set_req(1, 8'h5A, 5);
        cnt = 0;
        b = 0;
        while (cnt < 2 && b < 200) begin
            if (sample_tick && Sound == 8'h5A) cnt++;
            step();
            b++;
        end
        chk("mid_sound", Sound, 8'h5A);
        do_reset();
        g0_count = 0;
        seen10 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (grant != '0) g0_count++;
            if (Sound != 8'h00) seen10++;
        end
        chk("post_rst_grants", g0_count, 0);
        chk("post_rst_sound", seen10, 0);

        // requester 0 arriving during requester 2 playback
        do_reset();
        set_req(2, 8'h42, 10);
        step();
        step();
        for (int i = 0; i < 6; i++) step();
        chk("pre_playing", Sound, 8'h42);
        set_req(0, 8'h55, 2);
        step();
        chk("pre_pending", pending[0], 1);
        b = 0;
        silent = 0;
        got = 1'b0;
        while (!got && b < 1000) begin
            if (busy && Sound == 8'h00 && sample_tick) silent++;
            step();
            b++;
            if (grant[0]) got = 1'b1;
        end
        chk("pre_grant_seen", got, 1);
        chk("pre_immediate", (b == 1), PRE);
        chk("pre_gap_ticks", silent, PRE ? 0 : GAP);
        chk("pre_sound", Sound, 8'h55);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            req_sound = $urandom;
            req_len   = {$urandom, $urandom};
            for (int j = 0; j < NREQ; j++) begin
                if ($urandom_range(0, 23) == 0)
                    set_req(j, 8'($urandom_range(0, 255)), $urandom_range(0, 4));
            end
            step();
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sfx_arbiter.md
# sfx_arbiter

Sound-effect arbiter and sequencer for the audio path. Accepts play requests from up to `NUM_REQ` game-logic requesters, selects one by fixed priority, and drives the 8-bit `Sound` code into the tone/counter generator for a requested number of audio sample periods. It inserts a programmable silent gap between effects and returns `Sound` to silence when nothing is queued. It sits between game logic and the audio counter, paced by that counter's sample tick.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; index 0 has the highest priority.
- `LEN_W`, 16: width of the duration field, in sample ticks.
- `GAP_TICKS`, 64: silent sample ticks between consecutive effects; 0 disables the gap.

Ports:
- `Clk`  in  1: system clock, 50 MHz.
- `reset_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `sample_tick`  in  1: one-`Clk`-wide pulse per audio sample (44.1 kHz), synchronous to `Clk`.
- `req`  in  `NUM_REQ`: per-requester play strobe, one `Clk` wide.
- `req_sound`  in  `NUM_REQ`×8: sound code for each requester; sampled when its `req` bit is high.
- `req_len`  in  `NUM_REQ`×`LEN_W`: duration in sample ticks; sampled with `req`.
- `Sound`  out  8: code sent to the tone generator; 8'h00 means silence.
- `busy`  out  1: high in PLAY or GAP.
- `grant`  out  `NUM_REQ`: one-hot pulse, one `Clk` wide, when an effect starts.
- `active_id`  out  $clog2(`NUM_REQ`): index of the effect that is playing or last played.
- `pending`  out  `NUM_REQ`: queued-request bits.

## Operation
- Per-requester slot: a `req` bit sets `pending[i]` and captures `req_sound[i]` and `req_len[i]`.
  - A repeat `req` while the slot is already pending overwrites the captured values (latest wins); there is no second queue entry.
- States:
  - IDLE: `Sound`=0.
  - PLAY: `Sound`=captured code.
  - GAP: `Sound`=0.
- Transition IDLE→PLAY, when `pending`≠0:
  - Select the lowest pending index.
  - Load `remain` with `len`; a length of 0 is treated as 1.
  - Clear that `pending` bit, pulse `grant`, and update `active_id`.
- Countdown in PLAY:
  - `remain` decrements only on `sample_tick`.
  - On a tick with `remain`==1, exit to GAP with `remain`=`GAP_TICKS`, or to IDLE if `GAP_TICKS`=0.
- GAP: counts `GAP_TICKS` sample ticks, then goes to IDLE.
- IDLE always lasts at least 1 `Clk` before the next PLAY.
- Simultaneous events:
  - If `req[i]` arrives in the same cycle that slot i is granted, the new request remains pending with the new values.
  - Requests arriving during PLAY or GAP only queue.
- Reset, asynchronous, including mid-effect: all state is cleared.
  - `Sound`=0, `busy`=0, `grant`=0, `active_id`=0, `pending`=0, state=IDLE, `remain`=0.

## Timing
- All outputs are registered.
- A `req` at edge N:
  - `pending` is visible after edge N.
  - If IDLE, the grant happens at edge N+1: `grant`, `Sound`, and `busy` are valid after N+1. Latency is 2 `Clk` from the `req` edge to `Sound`.
- PLAY lasts exactly `len` `sample_tick` pulses. `Sound` drops to 0 on the `Clk` after the final counted tick.
- The `sample_tick` in the grant cycle is not counted.
- With back-to-back queued effects, the gap between effects is exactly `GAP_TICKS` ticks plus 1 `Clk` of IDLE.

## Configuration
- `SFX_PREEMPT_EN` defined:
  - In PLAY, a pending index lower than `active_id` preempts the current effect on the next edge.
  - The new effect is loaded exactly as in IDLE→PLAY, with no gap, and `grant` pulses.
  - The preempted effect is dropped, not re-queued.
  - GAP is never preempted.
- Not defined: an effect always plays to completion.

## Structure
- Package `sfx_pkg`:
  - State enum `sfx_state_t` (IDLE, PLAY, GAP).
  - `SOUND_SILENT`=8'h00.
  - Default `LEN_W`.
- Sub-module `sfx_prio_enc`: parameterized lowest-index-first priority encoder. It outputs a `valid` flag and the selected index. It is used for both the IDLE grant and the preemption check.

## Test plan
Bench setup: `sample_tick` pulses every 4 `Clk`.

- Reset, then `req[2]` with `req_sound`=8'h31, `req_len`=5: `Sound`=8'h31 appears 2 `Clk` after the `req`, lasts exactly 5 ticks, then `Sound`=0 and `busy` stays high for `GAP_TICKS`.
- `req[3]` and `req[1]` in the same cycle, both with `req_len`=3: `grant`=4'b0010 first, then 4'b1000 after the gap; `active_id` goes 1→3.
- `req_len`=0 on requester 0: the effect plays for 1 tick.
- `req[0]` pulsed twice during another effect, with codes 8'h10 then 8'h22: only 8'h22 plays, and exactly once.
- `reset_n` pulled low mid-PLAY (`remain`=3): all outputs go to 0 immediately; no grant follows after release while no new `req` arrives.
- `SFX_PREEMPT_EN` defined:
  - `req[0]` during requester 2's PLAY: `Sound` switches to requester 0's code on the next edge, with no gap.
  - Without the macro: requester 0 plays only after requester 2 completes and the gap elapses.
